// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage handshake and operand bus between the pipeline and the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd_in;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;
    modport master (output flush, start, op, a, b, rd_in, input busy, stall, done, result, rd_out);
    modport slave (input flush, start, op, a, b, rd_in, output busy, stall, done, result, rd_out);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV M-extension multiply/divide/remainder unit for the EX stage.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator, one bit per cycle.
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input logic clk,
    input logic rst,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] op_q;
    logic [RD_W-1:0] rd_q;
    logic neg_q, neg_r;
    logic [XLEN-1:0] ma, mb, result_q;
    logic [RD_W-1:0] rd_out_q;
    logic [2*XLEN-1:0] acc, acc_n, prod;
    logic [XLEN:0] sum, top, diff;
    logic [XLEN-1:0] quo, rem, calc_res, fast_res, mag_a, mag_b;
    logic sa, sb, fast, accept, last;
    assign accept = (state == IDLE) & bus.start & ~bus.flush;
    assign last = cnt == CW'(XLEN - 1);
    assign sa = bus.a[XLEN-1] & ~(bus.op[0] & (bus.op[1] | bus.op[2]));
    assign sb = bus.b[XLEN-1] & (bus.op[2] ? ~bus.op[0] : ~bus.op[1]);
    assign mag_a = sa ? -bus.a : bus.a;
    assign mag_b = sb ? -bus.b : bus.b;
    // Division by zero and signed overflow finish without iterating
    assign fast = bus.op[2] & ((bus.b == '0) | (~bus.op[0] & (bus.a == MIN_NEG) & (bus.b == '1)));
    assign fast_res = (bus.b == '0) ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
    always_comb begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma} : '0);
        top = acc[2*XLEN-1:XLEN-1];
        diff = top - {1'b0, mb};
        acc_n = op_q[2] ? (diff[XLEN] ? {top[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                        : {sum, acc[XLEN-1:1]};
        prod = neg_q ? -acc_n : acc_n;
        quo = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        rem = neg_r ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
        calc_res = op_q[2] ? (op_q[1] ? rem : quo)
                           : ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        state_n = state;
        state_n = (state == IDLE) ? (accept ? (fast ? DONE : CALC) : IDLE)
                : (state == CALC) ? (bus.flush ? IDLE : (last ? DONE : CALC))
                : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            op_q <= '0;
            rd_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ma <= '0;
            mb <= '0;
            acc <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q <= bus.op;
                rd_q <= bus.rd_in;
                neg_q <= sa ^ sb;
                neg_r <= sa;
                ma <= mag_a;
                mb <= mag_b;
                acc <= {{XLEN{1'b0}}, bus.op[2] ? mag_a : mag_b};
                cnt <= '0;
                if (fast) begin
                    result_q <= fast_res;
                    rd_out_q <= bus.rd_in;
                end
            end else if (state == CALC && !bus.flush) begin
                acc <= acc_n;
                cnt <= last ? cnt : cnt + 1'b1;
                if (last) begin
                    result_q <= calc_res;
                    rd_out_q <= rd_q;
                end
            end
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.stall = accept | (state == CALC);
    assign bus.done = (state == DONE) & ~bus.flush;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors against a cycle-countdown reference model of ex_muldiv.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ex_muldiv_if #(.XLEN(32), .RD_W(5)) mdif ();
    ex_muldiv #(.XLEN(32), .RD_W(5)) dut (.clk(clk), .rst(rst), .bus(mdif));
    always #5 clk = ~clk;
    int checks = 0;
    int fails = 0;
    int pend = 0;
    int cyc = 0;
    logic armed = 1'b0;
    logic [31:0] eres = '0, pres = '0;
    logic [4:0] erd = '0, prd = '0;
    logic lit_on = 1'b0;
    logic [31:0] lit_exp = '0;
    int lit_lat = 0;
    logic tmo = 1'b0;
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, uy;
        logic [63:0] p;
        int ix, iy;
        logic ovf;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        uy = longint'({32'b0, y});
        ix = signed'(x);
        iy = signed'(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(ix / iy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'(ix % iy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction
    function automatic logic is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction
    // Model: pend counts cycles left until the done cycle; 0 means idle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pend <= 0;
            eres <= '0;
            erd <= '0;
            armed <= 1'b1;
        end else if (pend > 1 && mdif.flush) begin
            pend <= 0;
        end else if (pend == 1) begin
            pend <= 0;
        end else if (pend > 1) begin
            pend <= pend - 1;
            if (pend == 2) begin
                eres <= pres;
                erd <= prd;
            end
        end else if (mdif.start && !mdif.flush) begin
            cyc <= 1;
            pres <= ref_res(mdif.op, mdif.a, mdif.b);
            prd <= mdif.rd_in;
            if (is_fast(mdif.op, mdif.a, mdif.b)) begin
                pend <= 1;
                eres <= ref_res(mdif.op, mdif.a, mdif.b);
                erd <= mdif.rd_in;
            end else begin
                pend <= 33;
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(mdif.busy), 32'(pend != 0));
            chk("stall", 32'(mdif.stall), 32'(pend > 1 || (pend == 0 && mdif.start && !mdif.flush)));
            chk("done", 32'(mdif.done), 32'(pend == 1 && !mdif.flush));
            chk("result", mdif.result, eres);
            chk("rd_out", 32'(mdif.rd_out), 32'(erd));
            chk("timeout", 32'(tmo), 32'(0));
            if (mdif.done && lit_on) begin
                chk("literal_result", mdif.result, lit_exp);
                chk("literal_latency", 32'(cyc), 32'(lit_lat));
            end
        end
    end
    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r,
                      input logic [31:0] e, input int lat);
        @(posedge clk); #1;
        lit_exp = e;
        lit_lat = lat;
        lit_on = 1'b1;
        mdif.start = 1'b1;
        mdif.op = o;
        mdif.a = x;
        mdif.b = y;
        mdif.rd_in = r;
        @(posedge clk); #1;
        mdif.start = 1'b0;
    endtask
    task automatic wait_done();
        int n = 1;
        while (!mdif.done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mdif.done) tmo = 1'b1;
    endtask
    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r,
                       input logic [31:0] e, input int lat);
        go(o, x, y, r, e, lat);
        wait_done();
    endtask
    initial begin
        mdif.flush = 1'b0;
        mdif.start = 1'b0;
        mdif.op = '0;
        mdif.a = '0;
        mdif.b = '0;
        mdif.rd_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 33);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 33);
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
        run(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 33);
        run(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 33);
        run(3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
        run(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, 1);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 1);
        run(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd15, 32'h0, 33);
        @(posedge clk); #1;
        mdif.start = 1'b1;
        mdif.flush = 1'b1;
        mdif.op = 3'd5;
        mdif.b = 32'd0;
        @(posedge clk); #1;
        mdif.start = 1'b0;
        mdif.flush = 1'b0;
        go(3'd4, 32'd1000, 32'd3, 5'd16, 32'd333, 33);
        lit_on = 1'b0;
        repeat (9) @(posedge clk);
        #1 mdif.flush = 1'b1;
        @(posedge clk); #1;
        mdif.flush = 1'b0;
        run(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 33);
        go(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd18, 32'hFFFF_FFEB, 33);
        repeat (4) @(posedge clk);
        #1;
        mdif.start = 1'b1;
        mdif.op = 3'd5;
        mdif.a = 32'd1;
        mdif.b = 32'd0;
        mdif.rd_in = 5'd31;
        @(posedge clk); #1;
        mdif.start = 1'b0;
        wait_done();
        go(3'd0, 32'd9, 32'd9, 5'd19, 32'd81, 33);
        lit_on = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run(3'd7, 32'hFFFF_FFFF, 32'd10, 5'd20, 32'd5, 33);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
